// File: rtl/msg_byte_streamer.sv
// msg_byte_streamer: buffers one byte-stream message, then replays it to the
// hash core as a gap-free burst with a stable length, and waits for the digest.
module msg_byte_streamer #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        M_valid,
    output logic [7:0]  M,
    output logic [63:0] input_lenght,
    input  logic        hash_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_buf [DEPTH];
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   r_len;
    logic               r_in_ready;
    logic               r_m_valid;
    logic [7:0]         r_m;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;

    logic               w_xfer;
    logic               w_store;
    logic               w_drop;
    logic               w_close;
    logic               w_rd_more;
    logic [CNT_W-1:0]   w_len_nxt;
    logic               w_m_valid_nxt;
    logic [7:0]         w_m_nxt;
    logic               w_done_nxt;

    // in_ready is a register, so acceptance only happens while in LOAD
    assign w_xfer    = in_valid & r_in_ready;
    assign w_store   = w_xfer & in_keep & (r_wr_cnt < CNT_W'(DEPTH));
    assign w_drop    = w_xfer & in_keep & (r_wr_cnt == CNT_W'(DEPTH));
    assign w_close   = w_xfer & in_last;
    assign w_len_nxt = r_wr_cnt + CNT_W'(w_store);
    assign w_rd_more = (r_rd_cnt < r_len);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:   if (w_close)    w_state_nxt = S_STREAM;
            S_STREAM: if (!w_rd_more) w_state_nxt = S_WAIT;
            S_WAIT:   if (hash_ready) w_state_nxt = S_LOAD;
            default:                  w_state_nxt = S_LOAD;
        endcase
    end

    // Next values of the registered outputs; first byte bypasses the buffer
    // when the closing beat is also the only stored byte
    always_comb begin
        w_m_valid_nxt = 1'b0;
        w_m_nxt       = 8'h00;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_close) begin
                    w_m_valid_nxt = 1'b1;
                    if (r_wr_cnt != '0) w_m_nxt = r_buf[0];
                    else if (w_store)   w_m_nxt = in_data;
                    else                w_m_nxt = 8'h00;
                end
            end
            S_STREAM: begin
                if (w_rd_more) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_nxt       = r_buf[r_rd_cnt[ADDR_W-1:0]];
                end
            end
            S_WAIT:   w_done_nxt = hash_ready;
            default:  w_done_nxt = 1'b0;
        endcase
    end

    // Message buffer write (contents need no reset)
    always_ff @(posedge clk) begin
        if (w_store) r_buf[r_wr_cnt[ADDR_W-1:0]] <= in_data;
    end

    // Counters, length, sticky overflow and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_len      <= '0;
            r_in_ready <= 1'b1;
            r_m_valid  <= 1'b0;
            r_m        <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_LOAD);
            r_busy     <= (w_state_nxt != S_LOAD);
            r_m_valid  <= w_m_valid_nxt;
            r_m        <= w_m_nxt;
            r_done     <= w_done_nxt;
            case (r_state)
                S_LOAD: begin
                    if (w_store) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    // wr_cnt==0 marks the opening beat of a message
                    if (w_drop)
                        r_overflow <= 1'b1;
                    else if (w_xfer && (in_keep || in_last) && (r_wr_cnt == '0))
                        r_overflow <= 1'b0;
                    if (w_close) begin
                        r_len    <= w_len_nxt;
                        r_rd_cnt <= CNT_W'(1);
                    end
                end
                S_STREAM: if (w_rd_more) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                S_WAIT:   if (hash_ready) r_wr_cnt <= '0;
                default:  r_wr_cnt <= '0;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign M_valid      = r_m_valid;
    assign M            = r_m;
    assign input_lenght = 64'(r_len);
    assign busy         = r_busy;
    assign done         = r_done;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_msg_byte_streamer.sv
// Scoreboard bench for msg_byte_streamer: stimulus queues expected core bytes,
// a negedge monitor pops and compares every M_valid beat.
module tb_msg_byte_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_keep;
    logic        in_last;
    logic        M_valid;
    logic [7:0]  M;
    logic [63:0] input_lenght;
    logic        hash_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    typedef struct packed {
        logic [7:0]  m;
        logic [63:0] len;
        logic        first;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_valid = 1'b0;

    msg_byte_streamer #(.DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_keep      (in_keep),
        .in_last      (in_last),
        .M_valid      (M_valid),
        .M            (M),
        .input_lenght (input_lenght),
        .hash_ready   (hash_ready),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void exp_byte(input logic [7:0] m, input int len, input bit first);
        exp_t e;
        e.m = m;
        e.len = 64'(len);
        e.first = first;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare each presented byte and burst continuity
    always @(negedge clk) begin
        if (busy === 1'b1) chk("in_ready_low_when_busy", 64'(in_ready), 64'd0);
        if (M_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(M), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("M", 64'(M), 64'(e.m));
                chk("input_lenght", input_lenght, e.len);
                chk("burst_continuity", 64'(prev_valid), e.first ? 64'd0 : 64'd1);
            end
        end
        prev_valid = (M_valid === 1'b1);
    end

    // One upstream beat, with random idle cycles before it
    task automatic send_beat(input logic [7:0] d, input logic keep, input logic last);
        int  n;
        logic rdy;
        n = $urandom_range(0, 2);
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = keep;
        in_last  = last;
        n = 0;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Core model: wait for WAIT, hold junk on the input, then pulse hash_ready
    task automatic run_core(input int lat);
        int n = 0;
        in_valid = 1'b1; in_data = 8'hEE; in_keep = 1'b1; in_last = 1'b1;
        while (!(busy === 1'b1 && M_valid === 1'b0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("wait_state_timeout", 64'd0, 64'd1);
        repeat (lat) begin @(posedge clk); #1; end
        chk("busy_in_wait", 64'(busy), 64'd1);
        chk("done_before_hash", 64'(done), 64'd0);
        hash_ready = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        @(posedge clk); #1;
        hash_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("in_ready_after_done", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        in_keep = 1'b0; in_last = 1'b0; hash_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_M_valid", 64'(M_valid), 64'd0);
        chk("rst_M", 64'(M), 64'd0);
        chk("rst_len", input_lenght, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // "abc"
        exp_byte(8'h61, 3, 1); exp_byte(8'h62, 3, 0); exp_byte(8'h63, 3, 0);
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        chk("abc_first_latency", 64'(M_valid), 64'd1);
        chk("abc_overflow", 64'(overflow), 64'd0);
        run_core(3);

        // Ignored keep=0 beat, then empty message
        send_beat(8'h55, 1'b0, 1'b0);
        chk("ignored_beat_busy", 64'(busy), 64'd0);
        chk("ignored_beat_ready", 64'(in_ready), 64'd1);
        exp_byte(8'h00, 0, 1);
        send_beat(8'h77, 1'b0, 1'b1);
        chk("empty_first_latency", 64'(M_valid), 64'd1);
        run_core(2);

        // 70 bytes into 64-deep buffer
        for (int i = 0; i < 64; i++) exp_byte(8'(i), 64, i == 0);
        for (int i = 0; i < 70; i++) send_beat(8'(i), 1'b1, i == 69);
        chk("ovf70_overflow", 64'(overflow), 64'd1);
        run_core(2);
        chk("ovf_sticky_in_load", 64'(overflow), 64'd1);

        // 65 bytes: closing beat itself is dropped
        for (int i = 0; i < 64; i++) exp_byte(8'(8'h80 + i), 64, i == 0);
        for (int i = 0; i < 65; i++) send_beat(8'(8'h80 + i), 1'b1, i == 64);
        chk("ovf65_overflow", 64'(overflow), 64'd1);
        run_core(1);

        // Back-to-back "a" then "bc"
        exp_byte(8'h61, 1, 1);
        send_beat(8'h61, 1'b1, 1'b1);
        chk("ovf_cleared", 64'(overflow), 64'd0);
        run_core(1);
        chk("len_hold_load", input_lenght, 64'd1);
        exp_byte(8'h62, 2, 1); exp_byte(8'h63, 2, 0);
        send_beat(8'h62, 1'b1, 1'b0);
        chk("len_hold_midload", input_lenght, 64'd1);
        send_beat(8'h63, 1'b1, 1'b1);
        chk("len_at_stream", input_lenght, 64'd2);
        run_core(4);

        // Reset at byte 5 of 10
        for (int i = 0; i < 10; i++) exp_byte(8'(8'hA0 + i), 10, i == 0);
        for (int i = 0; i < 10; i++) send_beat(8'(8'hA0 + i), 1'b1, i == 9);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_remaining", 64'(exp_q.size()), 64'd5);
        exp_q.delete();
        chk("abort_M_valid", 64'(M_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        exp_byte(8'h78, 2, 1); exp_byte(8'h79, 2, 0);
        send_beat(8'h78, 1'b1, 1'b0);
        send_beat(8'h79, 1'b1, 1'b1);
        run_core(2);

        repeat (2) @(posedge clk); #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
